tetris_drop_ctrl: RTL and testbench



---
 rtl/tetris_drop_ctrl.sv | 258 +++++++++++++++++++++++++
 tb/tb_tetris_drop_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tetris_drop_ctrl.sv
// Falling-piece sequencer for the 16x16 2-bit matrix frame buffer.
// Optional TETRIS_SOFT_DROP_EN adds soft_drop (drop interval / 8).
module tetris_drop_ctrl #(
  parameter int unsigned DROP_TICKS = 800000,
  parameter logic [3:0]  SPAWN_X    = 4'd3,
  parameter logic [3:0]  SPAWN_Y    = 4'd15,
  parameter logic [1:0]  PIECE_LVL  = 2'd3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       move_left,
  input  logic       move_right,
`ifdef TETRIS_SOFT_DROP_EN
  input  logic       soft_drop,
`endif
  output logic       fb_req,
  output logic       fb_we,
  output logic [7:0] fb_addr,
  output logic [1:0] fb_wdata,
  input  logic       fb_gnt,
  input  logic [1:0] fb_rdata,
  output logic       landed,
  output logic       game_over
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_SPAWN_RD  = 4'd1;
  localparam logic [3:0] S_SPAWN_CHK = 4'd2;
  localparam logic [3:0] S_SPAWN_WR  = 4'd3;
  localparam logic [3:0] S_FALL      = 4'd4;
  localparam logic [3:0] S_TGT_RD    = 4'd5;
  localparam logic [3:0] S_TGT_CHK   = 4'd6;
  localparam logic [3:0] S_ERASE     = 4'd7;
  localparam logic [3:0] S_DRAW      = 4'd8;
  localparam logic [3:0] S_LAND      = 4'd9;
  localparam logic [3:0] S_OVER      = 4'd10;

  localparam logic [23:0] LIM_FULL = 24'(DROP_TICKS - 1);
`ifdef TETRIS_SOFT_DROP_EN
  localparam logic [23:0] LIM_SOFT = 24'((DROP_TICKS >> 3) - 1);
`endif

  logic [3:0]  r_state;
  logic [23:0] r_cnt;
  logic        r_drop_p;
  logic        r_left_p;
  logic        r_right_p;
  logic [3:0]  r_row;
  logic [3:0]  r_col;
  logic [3:0]  r_trow;
  logic [3:0]  r_tcol;
  logic        r_is_drop;
  logic        r_req;
  logic        r_we;
  logic [7:0]  r_addr;
  logic [1:0]  r_wdata;
  logic        r_landed;
  logic        r_over;

  logic [23:0] w_lim;
  logic        w_active;
  logic        w_wrap;
  logic        w_mv_ok;
  logic        w_in_fall;
  logic        w_take_d;
  logic        w_take_l;
  logic        w_take_r;
  logic        w_grant;

`ifdef TETRIS_SOFT_DROP_EN
  assign w_lim = soft_drop ? LIM_SOFT : LIM_FULL;
`else
  assign w_lim = LIM_FULL;
`endif

  assign w_active  = (r_state != S_IDLE) && (r_state != S_OVER);
  // >= so a counter already past the soft limit wraps on the next tick
  assign w_wrap    = w_active && tick && (r_cnt >= w_lim);
  assign w_mv_ok   = w_active && !(move_left && move_right);
  assign w_in_fall = (r_state == S_FALL);
  assign w_take_d  = w_in_fall && r_drop_p;
  assign w_take_l  = w_in_fall && !r_drop_p && r_left_p;
  assign w_take_r  = w_in_fall && !r_drop_p && !r_left_p && r_right_p;
  assign w_grant   = r_req && fb_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_active && tick) begin
      r_cnt <= w_wrap ? 24'd0 : r_cnt + 24'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || r_state == S_LAND) begin
      r_drop_p  <= 1'b0;
      r_left_p  <= 1'b0;
      r_right_p <= 1'b0;
    end else begin
      r_drop_p  <= (r_drop_p & ~w_take_d) | w_wrap;
      r_left_p  <= (r_left_p & ~w_take_l) | (w_mv_ok & move_left);
      r_right_p <= (r_right_p & ~w_take_r) | (w_mv_ok & move_right);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_row     <= SPAWN_Y;
      r_col     <= SPAWN_X;
      r_trow    <= '0;
      r_tcol    <= '0;
      r_is_drop <= 1'b0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_landed  <= 1'b0;
      r_over    <= 1'b0;
    end else begin
      r_landed <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_SPAWN_RD;
            r_req   <= 1'b1;
            r_we    <= 1'b0;
            r_addr  <= {SPAWN_Y, SPAWN_X};
          end
        end
        S_SPAWN_RD: begin
          if (w_grant) begin
            r_req   <= 1'b0;
            r_state <= S_SPAWN_CHK;
          end
        end
        S_SPAWN_CHK: begin
          if (fb_rdata != 2'd0) begin
            r_state <= S_OVER;
            r_over  <= 1'b1;
          end else begin
            r_state <= S_SPAWN_WR;
            r_req   <= 1'b1;
            r_we    <= 1'b1;
            r_addr  <= {SPAWN_Y, SPAWN_X};
            r_wdata <= PIECE_LVL;
          end
        end
        S_SPAWN_WR: begin
          if (w_grant) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_row   <= SPAWN_Y;
            r_col   <= SPAWN_X;
            r_state <= S_FALL;
          end
        end
        S_FALL: begin
          if (w_take_d) begin
            if (r_row == 4'd0) begin
              r_state  <= S_LAND;
              r_landed <= 1'b1;
            end else begin
              r_trow    <= r_row - 4'd1;
              r_tcol    <= r_col;
              r_is_drop <= 1'b1;
              r_req     <= 1'b1;
              r_we      <= 1'b0;
              r_addr    <= {r_row - 4'd1, r_col};
              r_state   <= S_TGT_RD;
            end
          end else if (w_take_l && r_col != 4'd0) begin
            r_trow    <= r_row;
            r_tcol    <= r_col - 4'd1;
            r_is_drop <= 1'b0;
            r_req     <= 1'b1;
            r_we      <= 1'b0;
            r_addr    <= {r_row, r_col - 4'd1};
            r_state   <= S_TGT_RD;
          end else if (w_take_r && r_col != 4'd15) begin
            r_trow    <= r_row;
            r_tcol    <= r_col + 4'd1;
            r_is_drop <= 1'b0;
            r_req     <= 1'b1;
            r_we      <= 1'b0;
            r_addr    <= {r_row, r_col + 4'd1};
            r_state   <= S_TGT_RD;
          end
        end
        S_TGT_RD: begin
          if (w_grant) begin
            r_req   <= 1'b0;
            r_state <= S_TGT_CHK;
          end
        end
        S_TGT_CHK: begin
          if (fb_rdata != 2'd0) begin
            if (r_is_drop) begin
              r_state  <= S_LAND;
              r_landed <= 1'b1;
            end else begin
              r_state <= S_FALL;
            end
          end else begin
            r_state <= S_ERASE;
            r_req   <= 1'b1;
            r_we    <= 1'b1;
            r_addr  <= {r_row, r_col};
            r_wdata <= 2'd0;
          end
        end
        S_ERASE: begin
          if (w_grant) begin
            r_req   <= 1'b0;
            r_addr  <= {r_trow, r_tcol};
            r_wdata <= PIECE_LVL;
            r_state <= S_DRAW;
          end
        end
        S_DRAW: begin
          // one idle cycle after the erase grant, then request the draw
          if (w_grant) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_row   <= r_trow;
            r_col   <= r_tcol;
            r_state <= S_FALL;
          end else if (!r_req) begin
            r_req <= 1'b1;
          end
        end
        S_LAND: begin
          r_state <= S_SPAWN_RD;
          r_req   <= 1'b1;
          r_we    <= 1'b0;
          r_addr  <= {SPAWN_Y, SPAWN_X};
        end
        S_OVER: begin
          r_req <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign fb_req    = r_req;
  assign fb_we     = r_we;
  assign fb_addr   = r_addr;
  assign fb_wdata  = r_wdata;
  assign landed    = r_landed;
  assign game_over = r_over;

endmodule

// File: tb/tb_tetris_drop_ctrl.sv
// Directed bench for tetris_drop_ctrl with a behavioural frame buffer.
// Define TETRIS_SOFT_DROP_EN to also exercise soft_drop.
module tb_tetris_drop_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       move_left = 1'b0;
  logic       move_right = 1'b0;
`ifdef TETRIS_SOFT_DROP_EN
  logic       soft_drop = 1'b0;
`endif
  logic       fb_req;
  logic       fb_we;
  logic [7:0] fb_addr;
  logic [1:0] fb_wdata;
  logic       fb_gnt;
  logic [1:0] fb_rdata;
  logic       landed;
  logic       game_over;

  always #5 clk = ~clk;

  tetris_drop_ctrl #(
    .DROP_TICKS(8),
    .SPAWN_X(4'd3),
    .SPAWN_Y(4'd15),
    .PIECE_LVL(2'd3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tick(tick),
    .start(start),
    .move_left(move_left),
    .move_right(move_right),
`ifdef TETRIS_SOFT_DROP_EN
    .soft_drop(soft_drop),
`endif
    .fb_req(fb_req),
    .fb_we(fb_we),
    .fb_addr(fb_addr),
    .fb_wdata(fb_wdata),
    .fb_gnt(fb_gnt),
    .fb_rdata(fb_rdata),
    .landed(landed),
    .game_over(game_over)
  );

  logic [1:0]  mem [256];
  logic [1:0]  rdata_q = 2'd0;
  int unsigned r_wait = 0;
  int unsigned r_dly = 0;
  bit          rand_en = 1'b0;
  bit          pl_en = 1'b0;
  bit          clr_en = 1'b0;
  logic [7:0]  pl_addr = 8'd0;
  logic [1:0]  pl_data = 2'd0;
  int          n_acc = 0;
  int          n_land = 0;
  int          n_wide = 0;
  int          viol = 0;
  logic        p_pend = 1'b0;
  logic        p_land = 1'b0;
  logic [7:0]  s_addr = 8'd0;
  logic        s_we = 1'b0;
  logic [1:0]  s_wd = 2'd0;

  int checks = 0;
  int errors = 0;

  assign fb_gnt   = fb_req && (r_wait >= r_dly);
  assign fb_rdata = rdata_q;

  always @(posedge clk) begin
    if (clr_en) begin
      for (int i = 0; i < 256; i++) mem[i] <= 2'd0;
    end else if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end
    if (fb_req && fb_gnt) begin
      n_acc <= n_acc + 1;
      if (fb_we) mem[fb_addr] <= fb_wdata;
      else rdata_q <= mem[fb_addr];
      r_wait <= 0;
      r_dly  <= rand_en ? $urandom_range(5, 0) : 0;
    end else if (fb_req) begin
      r_wait <= r_wait + 1;
    end
    if (p_pend && (fb_req !== 1'b1 || fb_addr !== s_addr ||
                   fb_we !== s_we || fb_wdata !== s_wd))
      viol <= viol + 1;
    p_pend <= fb_req && !fb_gnt;
    s_addr <= fb_addr;
    s_we   <= fb_we;
    s_wd   <= fb_wdata;
    if (landed) n_land <= n_land + 1;
    if (landed && p_land) n_wide <= n_wide + 1;
    p_land <= landed;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic preload(input logic [7:0] a, input logic [1:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    @(negedge clk);
    pl_en   = 1'b0;
  endtask

  task automatic do_drop();
    for (int i = 0; i < 8; i++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
    cyc(40);
  endtask

  task automatic pulse_left();
    move_left = 1'b1;
    @(negedge clk);
    move_left = 1'b0;
    cyc(30);
  endtask

  function automatic int nonzero_cells();
    int nz = 0;
    for (int i = 0; i < 256; i++) if (mem[i] != 2'd0) nz++;
    return nz;
  endfunction

  int base;

  initial begin
    clr_en = 1'b1;
    cyc(2);
    chk("rst_req", 32'(fb_req), 0);
    chk("rst_we", 32'(fb_we), 0);
    chk("rst_addr", 32'(fb_addr), 0);
    chk("rst_wdata", 32'(fb_wdata), 0);
    chk("rst_landed", 32'(landed), 0);
    chk("rst_over", 32'(game_over), 0);
    clr_en = 1'b0;
    rst = 1'b0;
    cyc(2);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc(10);
    chk("spawn_cell", 32'(mem[8'hF3]), 3);
    chk("spawn_acc", 32'(n_acc), 2);
    cyc(20);
    chk("spawn_quiet", 32'(n_acc), 2);

    do_drop();
    chk("drop1_old", 32'(mem[8'hF3]), 0);
    chk("drop1_new", 32'(mem[8'hE3]), 3);
    chk("drop1_acc", 32'(n_acc), 5);

    repeat (3) pulse_left();
    chk("left3_cell", 32'(mem[8'hE0]), 3);
    chk("left3_old", 32'(mem[8'hE3]), 0);
    chk("left3_acc", 32'(n_acc), 14);
    pulse_left();
    chk("left_wall", 32'(n_acc), 14);
    move_left  = 1'b1;
    move_right = 1'b1;
    @(negedge clk);
    move_left  = 1'b0;
    move_right = 1'b0;
    cyc(30);
    chk("both_acc", 32'(n_acc), 14);
    chk("both_cell", 32'(mem[8'hE0]), 3);

    preload(8'hE1, 2'd2);
    move_right = 1'b1;
    @(negedge clk);
    move_right = 1'b0;
    cyc(30);
    chk("blk_mv_acc", 32'(n_acc), 15);
    chk("blk_mv_cell", 32'(mem[8'hE0]), 3);

    repeat (14) do_drop();
    chk("bottom_cell", 32'(mem[8'h00]), 3);
    chk("bottom_acc", 32'(n_acc), 57);
    chk("bottom_noland", 32'(n_land), 0);
    do_drop();
    chk("land0_pulse", 32'(n_land), 1);
    chk("land0_cell", 32'(mem[8'h00]), 3);
    chk("respawn", 32'(mem[8'hF3]), 3);
    chk("respawn_acc", 32'(n_acc), 59);

    preload(8'h53, 2'd3);
    repeat (10) do_drop();
    chk("stack1_cell", 32'(mem[8'h63]), 3);
    chk("stack1_land", 32'(n_land), 2);
    chk("stack1_acc", 32'(n_acc), 89);
    repeat (9) do_drop();
    chk("stack2_cell", 32'(mem[8'h73]), 3);
    chk("stack2_land", 32'(n_land), 3);
    chk("stack2_acc", 32'(n_acc), 116);
    chk("land_width", 32'(n_wide), 0);

    preload(8'hE3, 2'd1);
    do_drop();
    chk("over_flag", 32'(game_over), 1);
    chk("over_acc", 32'(n_acc), 118);
    chk("over_land", 32'(n_land), 4);
    tick = 1'b1;
    move_left = 1'b1;
    cyc(12);
    tick = 1'b0;
    move_left = 1'b0;
    cyc(10);
    chk("over_sticky", 32'(game_over), 1);
    chk("over_noreq", 32'(fb_req), 0);
    chk("over_quiet", 32'(n_acc), 118);

    rst = 1'b1;
    @(negedge clk);
    chk("rst2_over", 32'(game_over), 0);
    chk("rst2_req", 32'(fb_req), 0);
    chk("rst2_landed", 32'(landed), 0);
    clr_en = 1'b1;
    @(negedge clk);
    clr_en = 1'b0;
    rst = 1'b0;
    rand_en = 1'b1;
    base = n_acc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc(30);
    do_drop();
    do_drop();
    move_right = 1'b1;
    @(negedge clk);
    move_right = 1'b0;
    cyc(40);
    do_drop();
    chk("stress_cell", 32'(mem[8'hC4]), 3);
    chk("stress_nz", 32'(nonzero_cells()), 1);
    chk("stress_acc", 32'(n_acc - base), 14);
    chk("stress_stable", 32'(viol), 0);

`ifdef TETRIS_SOFT_DROP_EN
    soft_drop = 1'b1;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    cyc(40);
    soft_drop = 1'b0;
    chk("soft_cell", 32'(mem[8'hB4]), 3);
    chk("soft_old", 32'(mem[8'hC4]), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
